// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roller: FSM state encoding,
// LFSR seed/taps, legal face range and small step helpers.
package dice_pkg;

  // Roll sequencer states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ROLL     = 2'd1,
    ST_DONE     = 2'd2,
    ST_WAIT_REL = 2'd3
  } dice_state_e;

  // x^8 + x^6 + x^5 + x^4 + 1 -> XOR of bits 7,5,4,3 feeds bit 0
  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam logic [2:0] FACE_MIN = 3'b001;
  localparam logic [2:0] FACE_MAX = 3'b110;

  // One shift-left step of the Fibonacci LFSR
  function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
    logic fb;
    fb = ^(cur & LFSR_TAPS);
    return {cur[6:0], fb};
  endfunction

  // Next die face; anything at or beyond FACE_MAX wraps straight to FACE_MIN
  function automatic logic [2:0] face_step(input logic [2:0] cur);
    return (cur >= FACE_MAX) ? FACE_MIN : cur + 3'd1;
  endfunction

endpackage

// File: rtl/dice_roller_if.sv
// Button/face bundle between the dice roller and whatever drives/consumes it.
interface dice_roller_if;

  logic       roll_btn;
  logic [2:0] face;
  logic       face_valid;
  logic       rolling;

  // Button source / face consumer side
  modport master (
    output roll_btn,
    input  face,
    input  face_valid,
    input  rolling
  );

  // Dice roller side
  modport slave (
    input  roll_btn,
    output face,
    output face_valid,
    output rolling
  );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a counter debouncer. The output level
// only follows the synchronized input after it has disagreed with the
// current level for DEBOUNCE_CYCLES consecutive clocks.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Bring the raw button into the clock domain before anything looks at it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive disagreements; a single agreeing cycle restarts the count
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounced level and its stability counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/dice_roller.sv
// Electronic die: a debounced button press starts a spin of pseudo-random
// length, the face cycles 1..6 while spinning, and the final face is flagged
// with a one-cycle face_valid. A new roll needs the button released first.
// ROLL_CYCLES must be at least 1.
module dice_roller
  import dice_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ROLL_CYCLES     = 16
) (
  input  logic         clk,
  input  logic         rst,
  dice_roller_if.slave bus
);

  // Spin counter must hold ROLL_CYCLES + 7 without wrapping
  localparam int LEN_MAX = ROLL_CYCLES + 7;
  localparam int LEN_W   = $clog2(LEN_MAX + 1);

  dice_state_e      state_q;
  dice_state_e      state_d;
  logic [2:0]       face_q;
  logic [2:0]       face_d;
  logic [7:0]       lfsr_q;
  logic [7:0]       lfsr_d;
  logic [7:0]       lfsr_next;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_d;
  logic             level;
  logic             level_prev_q;
  logic             btn_rise;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (bus.roll_btn),
    .level_o (level)
  );

  assign btn_rise = level && !level_prev_q;

  // Free-running LFSR; the zero guard keeps it out of the lock-up state
  always_comb begin
    lfsr_next = lfsr_step(lfsr_q);
    lfsr_d    = (lfsr_next == 8'h00) ? LFSR_SEED : lfsr_next;
  end

  // LFSR state and previous debounced level for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q       <= LFSR_SEED;
      level_prev_q <= 1'b0;
    end else begin
      lfsr_q       <= lfsr_d;
      level_prev_q <= level;
    end
  end

  // Roll sequencing: face advances on every clock that ends in ROLL, so
  // DONE and WAIT_REL show the face that was on display in the last ROLL cycle
  always_comb begin
    state_d = state_q;
    face_d  = face_q;
    len_d   = len_q;
    case (state_q)
      ST_IDLE: begin
        if (btn_rise) begin
          state_d = ST_ROLL;
          len_d   = LEN_W'(ROLL_CYCLES) + LEN_W'(lfsr_q[2:0]);
          face_d  = face_step(face_q);
        end
      end
      ST_ROLL: begin
        if (len_q <= LEN_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          len_d  = len_q - LEN_W'(1);
          face_d = face_step(face_q);
        end
      end
      ST_DONE: begin
        state_d = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        if (!level) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, face and spin-length registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      face_q  <= FACE_MIN;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      face_q  <= face_d;
      len_q   <= len_d;
    end
  end

  assign bus.face       = face_q;
  assign bus.rolling    = (state_q == ST_ROLL);
  assign bus.face_valid = (state_q == ST_DONE);

endmodule
